lcd_char_emul: RTL
==================

Name: lcd_char_emul

Overview:
- Parametrised successor to the character-LCD bench emulator. Emulates an HD44780-class controller on the DUT's physical LCD pins (rs/rw/en/data) in 8-bit or 4-bit bus mode.
- Keeps a DDRAM address counter, models the busy flag with a programmable duration, and returns busy/address or bench-supplied data on reads.
- Logs every received byte into a drainable FIFO, so scenarios can check whole command streams, not just the last byte.
- Sits beside the DUT in the testbench top. Driven and checked through the set-injector, wait-event and check-level aliases.

Parameters:
- G_BUS_WIDTH, 8, physical data bus width; legal values are 8 and 4 (4 = nibble mode).
- G_CMD_FIFO_DEPTH, 16, received-byte FIFO depth; power of 2, at least 2.
- G_BUSY_CNT_WIDTH, 8, width of the busy-duration counter and its input.
- G_EN_SYNC_STAGES, 2, synchroniser stages on rs/rw/en/data; at least 1.

Ports:
- clk  in  1  bench clock.
- rst_n  in  1  reset.
- i_rs  in  1  LCD register select from DUT.
- i_rw  in  1  LCD read(1)/write(0) from DUT.
- i_en  in  1  LCD enable strobe from DUT.
- io_data  inout  G_BUS_WIDTH  LCD data bus.
- i_busy_flag_duration  in  G_BUSY_CNT_WIDTH  busy length in clk cycles after each completed write byte.
- i_wdata  in  8  byte returned on reads when i_wdata_sel=1.
- i_wdata_sel  in  1  read source select: 0 = {busy, addr[6:0]}, 1 = i_wdata.
- i_fifo_rd  in  1  pop FIFO head.
- o_rdata  out  9  last completed write, {rs, byte}.
- o_rdata_val  out  1  1-cycle pulse when o_rdata updates.
- o_fifo_rdata  out  9  FIFO head, {rs, byte}.
- o_fifo_empty  out  1  FIFO empty.
- o_fifo_full  out  1  FIFO full.
- o_fifo_level  out  $clog2(G_CMD_FIFO_DEPTH)+1  FIFO occupancy.
- o_overflow  out  1  sticky: a push was dropped because the FIFO was full.
- o_busy  out  1  busy flag.
- o_addr  out  7  DDRAM address counter.
- o_busy_violation  out  1  sticky: write accepted while busy (optional feature).

Behaviour:
- Clocking and reset: single clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0 except o_fifo_empty=1. Nibble phase = high; read phase = high; busy counter = 0.
- Input sampling: rs, rw, en and data pass through G_EN_SYNC_STAGES flops. Edge detect is sync'd en == 0 with previous == 1. Data, rs and rw are taken from the same synchronised stage.
- Write, 8-bit mode (rw=0 at edge): the cycle after detection, all of the following happen together:
  - o_rdata = {rs, data} and o_rdata_val pulses;
  - FIFO push;
  - busy counter loaded with i_busy_flag_duration.
- Write, 4-bit mode: data[3:0] is the bus. First edge latches the high nibble and toggles the phase. Second edge completes the byte, then the same actions as 8-bit mode. A lone nibble produces no output.
- Busy: o_busy = (counter != 0). Counter decrements once per cycle and saturates at 0. Duration 0 means never busy. A new write byte reloads the counter even if it is nonzero.
- Address counter, rs=1 write: addr += 1, modulo 128.
- Address counter, rs=0 commands:
  - 0x01 sets addr = 0;
  - 0x80|a sets addr = a[6:0];
  - all other commands leave addr unchanged.
- Read (rw=1):
  - io_data driven combinationally whenever raw i_rw=1 and i_en=1, otherwise high-Z.
  - Source: i_wdata_sel=1 returns i_wdata. Otherwise rs=0 returns {o_busy, addr}, and rs=1 returns 0x00.
  - 4-bit mode: high nibble first, then low nibble. Read phase toggles on each read edge.
  - Reads never push to the FIFO and never load busy. An rs=1 read increments addr on the completing edge.
- FIFO:
  - Push and pop in the same cycle: level unchanged, and the FIFO holds the new entry in place of the popped one (also legal when full).
  - Push when full, no pop: byte dropped, o_overflow set. o_rdata and o_rdata_val still update.
  - Pop when empty: ignored.
  - o_fifo_rdata is valid whenever not empty (show-ahead).
  - Pointers wrap modulo depth.
- Reset mid-transfer: partial nibble and read phase are discarded, FIFO is emptied, sticky flags are cleared.

Optional Feature:
- Macro: LCD_CHAR_EMUL_BUSY_CHECK_EN.
- Defined: a completed write byte while o_busy=1 sets o_busy_violation (sticky until reset) and issues $error with the byte value and simulation time.
- Undefined: o_busy_violation is tied 0, no message is issued, and the write is accepted normally in both cases.

Test Plan:
- 8-bit mode, duration=10, DUT writes rs=0 0x38 -> o_rdata=0x038, one o_rdata_val pulse, o_busy high for exactly 10 cycles, FIFO level 1.
- 4-bit mode, DUT writes rs=1 nibbles 0x4 then 0x1 -> single push of 0x141, addr 0->1; after the first nibble alone, no o_rdata_val.
- Writes 0x85, then rs=0 read with i_wdata_sel=0 while busy -> io_data = 0x85 with bit 7 = 1 (busy, addr 0x05); after busy expires -> 0x05.
- Depth=16: 17 writes without pops -> level 16, o_fifo_full=1, o_overflow=1, head=first byte; pop with simultaneous write -> level stays 16.
- i_wdata_sel=1, i_wdata=0xA5, 4-bit read -> 0xA, then 0x5 on the bus; FIFO is not pushed.
- BUSY_CHECK_EN defined, duration=50, two writes 5 cycles apart -> o_busy_violation=1; macro undefined -> stays 0.

Source files
------------

// File: rtl/lcd_char_emul.sv
// HD44780-class character-LCD emulator on the DUT's rs/rw/en/data pins, 8-bit or 4-bit bus.
// Latency: sync stages + 1 cycle from the en falling edge to o_rdata/FIFO push/busy load.
// Backpressure: none; FIFO pushes while full are dropped and o_overflow is set.
// Optional macro LCD_CHAR_EMUL_BUSY_CHECK_EN: flags a write byte completed while busy.
module lcd_char_emul #(
    parameter int G_BUS_WIDTH      = 8,
    parameter int G_CMD_FIFO_DEPTH = 16,
    parameter int G_BUSY_CNT_WIDTH = 8,
    parameter int G_EN_SYNC_STAGES = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_rs,
    input  logic                                  i_rw,
    input  logic                                  i_en,
    inout  wire  [G_BUS_WIDTH-1:0]                io_data,
    input  logic [G_BUSY_CNT_WIDTH-1:0]           i_busy_flag_duration,
    input  logic [7:0]                            i_wdata,
    input  logic                                  i_wdata_sel,
    input  logic                                  i_fifo_rd,
    output logic [8:0]                            o_rdata,
    output logic                                  o_rdata_val,
    output logic [8:0]                            o_fifo_rdata,
    output logic                                  o_fifo_empty,
    output logic                                  o_fifo_full,
    output logic [$clog2(G_CMD_FIFO_DEPTH):0]     o_fifo_level,
    output logic                                  o_overflow,
    output logic                                  o_busy,
    output logic [6:0]                            o_addr,
    output logic                                  o_busy_violation
);

    localparam int  AW     = $clog2(G_CMD_FIFO_DEPTH);
    localparam int  NS     = G_EN_SYNC_STAGES;
    localparam bit  NIBBLE = (G_BUS_WIDTH == 4);

    // Synchroniser chains; all pins are taken from the same (last) stage.
    logic [NS-1:0]          rs_sync_q, rw_sync_q, en_sync_q;
    logic [G_BUS_WIDTH-1:0] data_sync_q [NS];
    logic                   en_prev_q;

    logic                   nib_phase_q;    // 1 = next write nibble is the high one
    logic [3:0]             nib_hi_q;
    logic                   rd_phase_q;     // 1 = next read nibble is the high one

    logic [8:0]             rdata_q, rdata_d;
    logic                   rdata_val_q;
    logic [G_BUSY_CNT_WIDTH-1:0] busy_cnt_q, busy_cnt_d;
    logic [6:0]             addr_q, addr_d;
    logic                   overflow_q;

    logic [8:0]             fifo_mem [G_CMD_FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]            level_q, level_d;

    logic                   rs_s, rw_s, en_s;
    logic [7:0]             data_ext;
    logic                   fall, wr_edge, rd_edge, wr_done, rd_done;
    logic [7:0]             wr_byte;
    logic                   fifo_full, fifo_empty, push, pop, push_ok;
    logic [7:0]             rd_byte, rd_bus;

    assign rs_s     = rs_sync_q[NS-1];
    assign rw_s     = rw_sync_q[NS-1];
    assign en_s     = en_sync_q[NS-1];
    assign data_ext = 8'(data_sync_q[NS-1]);

    assign fall     = en_prev_q & ~en_s;
    assign wr_edge  = fall & ~rw_s;
    assign rd_edge  = fall & rw_s;
    // In nibble mode only the second (low) nibble completes a transfer.
    assign wr_done  = wr_edge & (NIBBLE ? ~nib_phase_q : 1'b1);
    assign rd_done  = rd_edge & (NIBBLE ? ~rd_phase_q : 1'b1);
    assign wr_byte  = NIBBLE ? {nib_hi_q, data_ext[3:0]} : data_ext;

    assign fifo_full  = (level_q == (AW+1)'(G_CMD_FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign push       = wr_done;
    assign pop        = i_fifo_rd & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign push_ok    = push & (~fifo_full | pop);

    // Shift rs/rw/en/data through the synchroniser and remember the previous en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_sync_q <= '0;
            rw_sync_q <= '0;
            en_sync_q <= '0;
            en_prev_q <= 1'b0;
            for (int i = 0; i < NS; i++) data_sync_q[i] <= '0;
        end else begin
            rs_sync_q[0]   <= i_rs;
            rw_sync_q[0]   <= i_rw;
            en_sync_q[0]   <= i_en;
            data_sync_q[0] <= io_data;
            for (int i = 1; i < NS; i++) begin
                rs_sync_q[i]   <= rs_sync_q[i-1];
                rw_sync_q[i]   <= rw_sync_q[i-1];
                en_sync_q[i]   <= en_sync_q[i-1];
                data_sync_q[i] <= data_sync_q[i-1];
            end
            en_prev_q <= en_s;
        end
    end

    // Nibble-mode phase tracking for writes and reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nib_phase_q <= 1'b1;
            nib_hi_q    <= '0;
            rd_phase_q  <= 1'b1;
        end else if (NIBBLE) begin
            if (wr_edge) begin
                if (nib_phase_q) nib_hi_q <= data_ext[3:0];
                nib_phase_q <= ~nib_phase_q;
            end
            if (rd_edge) rd_phase_q <= ~rd_phase_q;
        end
    end

    // Next-state for the captured byte, busy counter, address counter and FIFO level.
    always_comb begin
        rdata_d    = rdata_q;
        busy_cnt_d = busy_cnt_q;
        addr_d     = addr_q;
        level_d    = level_q;
        if (busy_cnt_q != '0) busy_cnt_d = busy_cnt_q - 1'b1;
        if (wr_done) begin
            rdata_d    = {rs_s, wr_byte};
            busy_cnt_d = i_busy_flag_duration;
            if (rs_s)                  addr_d = addr_q + 7'd1;
            else if (wr_byte == 8'h01) addr_d = 7'd0;
            else if (wr_byte[7])       addr_d = wr_byte[6:0];
        end else if (rd_done && rs_s) begin
            addr_d = addr_q + 7'd1;
        end
        if (push_ok && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push_ok) level_d = level_q - 1'b1;
    end

    // Controller state registers and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q     <= '0;
            rdata_val_q <= 1'b0;
            busy_cnt_q  <= '0;
            addr_q      <= '0;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            rdata_q     <= rdata_d;
            rdata_val_q <= wr_done;
            busy_cnt_q  <= busy_cnt_d;
            addr_q      <= addr_d;
            level_q     <= level_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !push_ok) overflow_q <= 1'b1;
        end
    end

    // FIFO storage; contents are only visible through the level-gated head.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= {rs_s, wr_byte};
    end

    // Read data follows the raw pins so the DUT sees it while en is still high.
    always_comb begin
        rd_byte = i_wdata_sel ? i_wdata : (i_rs ? 8'h00 : {o_busy, addr_q});
        rd_bus  = rd_byte;
        if (NIBBLE) rd_bus = {4'h0, rd_phase_q ? rd_byte[7:4] : rd_byte[3:0]};
    end

    assign io_data = (i_rw && i_en) ? rd_bus[G_BUS_WIDTH-1:0] : {G_BUS_WIDTH{1'bz}};

`ifdef LCD_CHAR_EMUL_BUSY_CHECK_EN
    logic busy_viol_q;
    // Sticky flag for a byte completed before the busy window expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_viol_q <= 1'b0;
        end else if (wr_done && o_busy) begin
            busy_viol_q <= 1'b1;
            $error("lcd_char_emul: byte %02h written while busy at %0t", wr_byte, $time);
        end
    end
    assign o_busy_violation = busy_viol_q;
`else
    assign o_busy_violation = 1'b0;
`endif

    assign o_rdata      = rdata_q;
    assign o_rdata_val  = rdata_val_q;
    assign o_fifo_rdata = fifo_empty ? 9'h000 : fifo_mem[rd_ptr_q];
    assign o_fifo_empty = fifo_empty;
    assign o_fifo_full  = fifo_full;
    assign o_fifo_level = level_q;
    assign o_overflow   = overflow_q;
    assign o_busy       = (busy_cnt_q != '0);
    assign o_addr       = addr_q;

endmodule
